// File: rtl/truth_table_sweeper_if.sv
// Handshake and result bundle between a truth_table_sweeper and its environment.
// The environment (master) requests sweeps and supplies the two function outputs.
// The sweeper (slave) drives the input vector and reports the captured tables.
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  logic                 start;
  logic [N_IN-1:0]      vec_out;
  logic                 fa_in;
  logic                 fb_in;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   table_a;
  logic [2**N_IN-1:0]   table_b;
  logic                 mismatch;
  logic [N_IN-1:0]      first_bad;
  logic [N_IN:0]        bad_count;

  modport master (
    output start, fa_in, fb_in,
    input  vec_out, busy, done, table_a, table_b, mismatch, first_bad, bad_count
  );

  modport slave (
    input  start, fa_in, fb_in,
    output vec_out, busy, done, table_a, table_b, mismatch, first_bad, bad_count
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: steps an input vector through every combination in
// ascending order, samples two implementations of the same Boolean function
// after a programmable settle time, and records both output columns plus
// mismatch statistics (flag, lowest bad index, number of bad indices).
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  truth_table_sweeper_if.slave   bus
);

  localparam int                 NVEC     = 2**N_IN;
  localparam int                 CNT_W    = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0]   SETTLE_C = CNT_W'(SETTLE);
  localparam logic [N_IN-1:0]    LAST_VEC = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_IN-1:0]    vec_q, vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NVEC-1:0]    table_a_q, table_a_d;
  logic [NVEC-1:0]    table_b_q, table_b_d;
  logic               mismatch_q, mismatch_d;
  logic [N_IN-1:0]    first_bad_q, first_bad_d;
  logic [N_IN:0]      bad_count_q, bad_count_d;

  // Register update; reset clears results as well as control, so an
  // aborted sweep leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      cnt_q       <= '0;
      table_a_q   <= '0;
      table_b_q   <= '0;
      mismatch_q  <= 1'b0;
      first_bad_q <= '0;
      bad_count_q <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      table_a_q   <= table_a_d;
      table_b_q   <= table_b_d;
      mismatch_q  <= mismatch_d;
      first_bad_q <= first_bad_d;
      bad_count_q <= bad_count_d;
    end
  end

  // Next-state logic: start arms a fresh sweep, RUN alternates settle
  // countdown and sampling, DONE lasts exactly one cycle.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    table_a_d   = table_a_q;
    table_b_d   = table_b_q;
    mismatch_d  = mismatch_q;
    first_bad_d = first_bad_q;
    bad_count_d = bad_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_RUN;
          vec_d       = '0;
          cnt_d       = SETTLE_C;
          table_a_d   = '0;
          table_b_d   = '0;
          mismatch_d  = 1'b0;
          first_bad_d = '0;
          bad_count_d = '0;
        end
      end

      S_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          table_a_d[vec_q] = bus.fa_in;
          table_b_d[vec_q] = bus.fb_in;
          if (bus.fa_in != bus.fb_in) begin
            bad_count_d = bad_count_q + 1'b1;
            // Only the first (lowest, since the sweep ascends) bad index is kept.
            if (!mismatch_q) begin
              mismatch_d  = 1'b1;
              first_bad_d = vec_q;
            end
          end
          // The last vector stays on the bus; wrap happens only at the next start.
          if (vec_q != LAST_VEC) begin
            vec_d = vec_q + 1'b1;
            cnt_d = SETTLE_C;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.vec_out   = vec_q;
  assign bus.busy      = (state_q == S_RUN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.table_a   = table_a_q;
  assign bus.table_b   = table_b_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.first_bad = first_bad_q;
  assign bus.bad_count = bad_count_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper: one instance with SETTLE=1 and one with
// SETTLE=0, both N_IN=3, fed by behavioural models of the functions under test.
module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;

  truth_table_sweeper_if #(.N_IN(3)) if1 ();
  truth_table_sweeper_if #(.N_IN(3)) if0 ();

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function models; x = vec[2], y = vec[1], z = vec[0].
  // mode1: 0 = equivalent pair, 1 = faulty B=x, 2 = A=1 / B=0
  int mode1;
  logic x1, y1, z1;
  always_comb begin
    x1 = if1.vec_out[2];
    y1 = if1.vec_out[1];
    z1 = if1.vec_out[0];
    if1.fa_in = (x1 & ~y1 & ~z1) | (x1 & ~y1 & z1) | (x1 & y1 & ~z1);
    if1.fb_in = (x1 & ~y1) | (x1 & ~z1);
    if (mode1 == 1) if1.fb_in = x1;
    if (mode1 == 2) begin
      if1.fa_in = 1'b1;
      if1.fb_in = 1'b0;
    end
  end

  assign if0.fa_in = 1'b1;
  assign if0.fb_in = 1'b0;

  // Observation mux for the table-driven loop.
  int sel;
  logic       o_busy, o_done, o_mm;
  logic [7:0] o_ta, o_tb;
  logic [2:0] o_fb, o_vec;
  logic [3:0] o_bc;
  always_comb begin
    if (sel == 1) begin
      o_busy = if1.busy;    o_done = if1.done;    o_mm = if1.mismatch;
      o_ta = if1.table_a;   o_tb = if1.table_b;   o_fb = if1.first_bad;
      o_bc = if1.bad_count; o_vec = if1.vec_out;
    end else begin
      o_busy = if0.busy;    o_done = if0.done;    o_mm = if0.mismatch;
      o_ta = if0.table_a;   o_tb = if0.table_b;   o_fb = if0.first_bad;
      o_bc = if0.bad_count; o_vec = if0.vec_out;
    end
  end

  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vec"},  {29'd0, o_vec}, 32'd0);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_ta"},   {24'd0, o_ta}, 32'd0);
    chk({tag, "_tb"},   {24'd0, o_tb}, 32'd0);
    chk({tag, "_mm"},   {31'd0, o_mm}, 32'd0);
    chk({tag, "_fb"},   {29'd0, o_fb}, 32'd0);
    chk({tag, "_bc"},   {28'd0, o_bc}, 32'd0);
  endtask

  task automatic set_start(input logic v);
    if (sel == 1) if1.start = v;
    else          if0.start = v;
  endtask

  // Pulse start for one cycle, count busy cycles (bounded), leave the bench
  // sampling in the cycle where busy has just dropped.
  task automatic run_sweep(output int busy_cycles);
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    busy_cycles = 0;
    while (o_busy && busy_cycles < 200) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    int         sel;
    int         mode;
    int         exp_busy;
    logic [7:0] exp_ta;
    logic [7:0] exp_tb;
    logic       exp_mm;
    logic [2:0] exp_fb;
    logic [3:0] exp_bc;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int   bc;
    int   guard;
    checks   = 0;
    errors   = 0;
    sel      = 1;
    mode1    = 0;
    if1.start = 1'b0;
    if0.start = 1'b0;

    vecs[0] = '{sel: 1, mode: 0, exp_busy: 16, exp_ta: 8'h70, exp_tb: 8'h70, exp_mm: 1'b0, exp_fb: 3'd0, exp_bc: 4'd0};
    vecs[1] = '{sel: 1, mode: 1, exp_busy: 16, exp_ta: 8'h70, exp_tb: 8'hF0, exp_mm: 1'b1, exp_fb: 3'd7, exp_bc: 4'd1};
    vecs[2] = '{sel: 0, mode: 0, exp_busy: 8,  exp_ta: 8'hFF, exp_tb: 8'h00, exp_mm: 1'b1, exp_fb: 3'd0, exp_bc: 4'd8};

    // Reset / idle
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sel = 1;
    check_all_zero("rst1");
    sel = 0;
    check_all_zero("rst0");
    repeat (3) @(negedge clk);
    sel = 1;
    chk("idle_busy1", {31'd0, o_busy}, 32'd0);

    // Table-driven sweeps
    for (int i = 0; i < 3; i++) begin
      sel   = vecs[i].sel;
      mode1 = vecs[i].mode;
      run_sweep(bc);
      chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_busy);
      chk($sformatf("v%0d_done", i), {31'd0, o_done}, 32'd1);
      chk($sformatf("v%0d_ta", i), {24'd0, o_ta}, {24'd0, vecs[i].exp_ta});
      chk($sformatf("v%0d_tb", i), {24'd0, o_tb}, {24'd0, vecs[i].exp_tb});
      chk($sformatf("v%0d_mm", i), {31'd0, o_mm}, {31'd0, vecs[i].exp_mm});
      chk($sformatf("v%0d_fb", i), {29'd0, o_fb}, {29'd0, vecs[i].exp_fb});
      chk($sformatf("v%0d_bc", i), {28'd0, o_bc}, {28'd0, vecs[i].exp_bc});
      chk($sformatf("v%0d_vec_hold", i), {29'd0, o_vec}, 32'd7);
      @(negedge clk);
      chk($sformatf("v%0d_done_1cyc", i), {31'd0, o_done}, 32'd0);
      chk($sformatf("v%0d_ta_hold", i), {24'd0, o_ta}, {24'd0, vecs[i].exp_ta});
    end

    // Reset mid-sweep at vec_out == 4, with nonzero partial results
    sel   = 1;
    mode1 = 2;
    @(negedge clk);
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    guard = 0;
    while (o_vec != 3'd4 && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    chk("mid_reached_vec4", {29'd0, o_vec}, 32'd4);
    chk("mid_partial_ta", {24'd0, o_ta}, 32'h0F);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("mid_rst");
    mode1 = 0;
    run_sweep(bc);
    chk("post_rst_busy_cycles", bc, 16);
    chk("post_rst_ta", {24'd0, o_ta}, 32'h70);
    chk("post_rst_tb", {24'd0, o_tb}, 32'h70);
    chk("post_rst_mm", {31'd0, o_mm}, 32'd0);
    @(negedge clk);

    // start held high through a whole sweep
    @(negedge clk);
    if1.start = 1'b1;
    @(negedge clk);
    bc = 0;
    while (o_busy && bc < 200) begin
      bc++;
      @(negedge clk);
    end
    chk("held_busy_cycles", bc, 16);
    chk("held_done", {31'd0, o_done}, 32'd1);
    chk("held_done_ta", {24'd0, o_ta}, 32'h70);
    @(negedge clk);
    chk("held_idle_busy", {31'd0, o_busy}, 32'd0);
    chk("held_idle_done", {31'd0, o_done}, 32'd0);
    chk("held_idle_ta", {24'd0, o_ta}, 32'h70);
    @(negedge clk);
    chk("held_restart_busy", {31'd0, o_busy}, 32'd1);
    chk("held_restart_ta_clr", {24'd0, o_ta}, 32'h00);
    chk("held_restart_vec", {29'd0, o_vec}, 32'd0);
    if1.start = 1'b0;
    guard = 0;
    while (!o_done && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    chk("held_second_done", {31'd0, o_done}, 32'd1);
    chk("held_second_ta", {24'd0, o_ta}, 32'h70);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
